// File: rtl/timer_apb_slave.sv
// ---------------------------------------------------------------------------
// timer_apb_slave
//   APB register front-end for an 8-bit timer. It holds the reload value (TDR),
//   the control register (TCR) and the sticky status flags (TSR), and it
//   exposes the live count (TCNT) read-only.
//
//   Register map
//     0x00 TDR  R/W   reload value
//     0x01 TCR  R/W   [7] load (one-cycle strobe), [5] down, [4] enable,
//                     [1:0] clock select; bits 6,3,2 read 0
//     0x02 TSR  R/W0C [0] overflow, [1] underflow; bits [7:2] read 0
//     0x03 TCNT RO    live count from the counter core
//   An address above 0x03, or a write to 0x03, completes with pslverr=1.
//
//   Build option
//     TIMER_APB_WAIT_STATE_EN  inserts one wait state (SETUP->WAIT->ACCESS).
//
//   Ports
//     pclk, presetn              clock, asynchronous active-low reset
//     psel, penable, pwrite,
//     paddr[7:0], pwdata[7:0]    APB requester inputs
//     prdata[7:0], pready,
//     pslverr                    APB completer outputs
//     tdr[7:0], tcr[7:0],
//     tsr[1:0]                   register contents to the counter core
//     ovf_set, udf_set           one-cycle status set pulses from the core
//     tcnt[7:0]                  live count from the core
//     irq                        interrupt, high while any status flag is set
// ---------------------------------------------------------------------------
module timer_apb_slave (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] tdr,
  output logic [7:0] tcr,
  output logic [1:0] tsr,
  input  logic       ovf_set,
  input  logic       udf_set,
  input  logic [7:0] tcnt,
  output logic       irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_e;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;
  localparam logic [7:0] TCR_WMASK = 8'hB3;
  localparam logic [7:0] TCR_LOAD  = 8'h80;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [1:0] tsr_q, tsr_d;
  logic       capture_s;
  logic       wr_en_s;

  // An access is rejected when it targets an unmapped address or writes TCNT.
  function automatic logic access_err(input logic [7:0] addr, input logic wr);
    return (addr > ADDR_TCNT) || (wr && (addr == ADDR_TCNT));
  endfunction

  // State, captured request and register flops.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      addr_q  <= 8'h00;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      tdr_q   <= 8'h00;
      tcr_q   <= 8'h00;
      tsr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      tdr_q   <= tdr_d;
      tcr_q   <= tcr_d;
      tsr_q   <= tsr_d;
    end
  end

  // Next-state logic and request capture. The request is latched when the
  // setup phase is seen, because a back-to-back requester already presents
  // the next address during the completing cycle.
  always_comb begin
    state_d   = state_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d   = ST_SETUP;
          capture_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else begin
`ifdef TIMER_APB_WAIT_STATE_EN
          state_d = ST_WAIT;
`else
          state_d = ST_ACCESS;
`endif
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (psel && !penable) begin
          state_d   = ST_SETUP;
          capture_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (capture_s) begin
      addr_d  = paddr;
      wr_d    = pwrite;
      wdata_d = pwdata;
    end else begin
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
    end
  end

  // Completion outputs: response, read mux and write strobe.
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 8'h00;
    wr_en_s = 1'b0;
    if (state_q == ST_ACCESS) begin
      pready = 1'b1;
      if (access_err(addr_q, wr_q)) begin
        pslverr = 1'b1;
      end else if (wr_q) begin
        wr_en_s = 1'b1;
      end else begin
        case (addr_q)
          ADDR_TDR:  prdata = tdr_q;
          ADDR_TCR:  prdata = tcr_q;
          ADDR_TSR:  prdata = {6'b000000, tsr_q};
          ADDR_TCNT: prdata = tcnt;
          default:   prdata = 8'h00;
        endcase
      end
    end else begin
      pready = 1'b0;
    end
  end

  // Register update. The load bit is a strobe that drops one cycle after it
  // was written; hardware status sets override a same-cycle software clear.
  always_comb begin
    tdr_d = tdr_q;
    tcr_d = tcr_q & ~TCR_LOAD;
    tsr_d = tsr_q;
    if (wr_en_s) begin
      case (addr_q)
        ADDR_TDR: tdr_d = wdata_q;
        ADDR_TCR: tcr_d = wdata_q & TCR_WMASK;
        ADDR_TSR: tsr_d = tsr_q & wdata_q[1:0];
        default:  tdr_d = tdr_q;
      endcase
    end else begin
      tdr_d = tdr_q;
    end
    tsr_d = tsr_d | {udf_set, ovf_set};
  end

  assign tdr = tdr_q;
  assign tcr = tcr_q;
  assign tsr = tsr_q;
  assign irq = |tsr_q;

endmodule

// File: tb/tb_timer_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_timer_apb_slave
//   Drives APB transfers from a queue (with optional back-to-back chaining,
//   idle gaps and setup-phase aborts) and compares every cycle against a
//   register-level model of the timer front-end, plus directed literal checks.
// ---------------------------------------------------------------------------
module tb_timer_apb_slave;

`ifdef TIMER_APB_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic       pclk = 1'b0;
  logic       presetn, psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic [7:0] tdr, tcr;
  logic [1:0] tsr;
  logic       ovf_set, udf_set;
  logic [7:0] tcnt;
  logic       irq;

  timer_apb_slave dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .tdr(tdr), .tcr(tcr), .tsr(tsr),
    .ovf_set(ovf_set), .udf_set(udf_set), .tcnt(tcnt), .irq(irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] a;
    bit         w;
    logic [7:0] d;
    int         gap;
    bit         abort;
  } txn_t;

  txn_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hist[$];
  bit   rand_side   = 1'b0;
  bit   udf_at_done = 1'b0;
  bit   rst_at_done = 1'b0;

  // transfer currently in its completing cycle (as the bench expects it)
  bit         cur_done = 1'b0;
  logic [7:0] cur_a = 8'h00;
  bit         cur_w = 1'b0;
  logic [7:0] cur_d = 8'h00;

  logic [7:0] last_rd  = 8'h00;
  logic       last_err = 1'b0;

  // register-level model
  logic [7:0] m_tdr = 8'h00;
  logic [7:0] m_tcr = 8'h00;
  logic [1:0] m_tsr = 2'b00;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic bit is_err(input logic [7:0] a, input bit w);
    return (a > 8'd3) || (w && a == 8'd3);
  endfunction

  always @(posedge pclk) cyc <= cyc + 1;

  // Model: registers change only on completed legal writes and status pulses.
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_tdr <= 8'h00;
      m_tcr <= 8'h00;
      m_tsr <= 2'b00;
    end else begin
      logic [7:0] ntdr, ntcr;
      logic [1:0] ntsr;
      ntdr = m_tdr;
      ntcr = m_tcr & 8'h7F;
      ntsr = m_tsr;
      if (cur_done && cur_w && !is_err(cur_a, cur_w)) begin
        if (cur_a == 8'd0) ntdr = cur_d;
        else if (cur_a == 8'd1) ntcr = cur_d & 8'hB3;
        else ntsr = m_tsr & cur_d[1:0];
      end
      ntsr = ntsr | {udf_set, ovf_set};
      m_tdr <= ntdr;
      m_tcr <= ntcr;
      m_tsr <= ntsr;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge pclk) begin
    logic       err;
    logic [7:0] exp_rd;
    err    = is_err(cur_a, cur_w);
    exp_rd = 8'h00;
    if (cur_done && !cur_w && !err) begin
      if (cur_a == 8'd0) exp_rd = m_tdr;
      else if (cur_a == 8'd1) exp_rd = m_tcr;
      else if (cur_a == 8'd2) exp_rd = {6'd0, m_tsr};
      else exp_rd = tcnt;
    end
    chk("pready", {31'd0, pready}, {31'd0, cur_done});
    chk("pslverr", {31'd0, pslverr}, {31'd0, cur_done && err});
    chk("prdata", {24'd0, prdata}, {24'd0, exp_rd});
    chk("tdr", {24'd0, tdr}, {24'd0, m_tdr});
    chk("tcr", {24'd0, tcr}, {24'd0, m_tcr});
    chk("tsr", {30'd0, tsr}, {30'd0, m_tsr});
    chk("irq", {31'd0, irq}, {31'd0, |m_tsr});
    if (pready === 1'b1) begin
      last_rd  = prdata;
      last_err = pslverr;
      hist.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
    if (rand_side) begin
      ovf_set = ($urandom_range(0, 9) == 0);
      udf_set = ($urandom_range(0, 9) == 0);
      tcnt    = 8'($urandom);
    end else begin
      ovf_set = 1'b0;
      udf_set = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] a, input bit w, input logic [7:0] d,
                      input int gap, input bit abort);
    txn_t t;
    t.a = a; t.w = w; t.d = d; t.gap = gap; t.abort = abort;
    q.push_back(t);
  endtask

  task automatic drive_setup(input txn_t t);
    psel = 1'b1; penable = 1'b0; paddr = t.a; pwrite = t.w; pwdata = t.d;
  endtask

  task automatic drain();
    txn_t t;
    bit   pre = 1'b0;
    while (q.size() > 0) begin
      t = q.pop_front();
      if (!pre) begin
        drive_setup(t);
        tick();
      end
      pre = 1'b0;
      if (t.abort) begin
        psel = 1'b0; penable = 1'b0;
        tick();
      end else begin
        penable = 1'b1;
        tick();
        for (int i = 0; i < WS; i++) tick();
        cur_done = 1'b1; cur_a = t.a; cur_w = t.w; cur_d = t.d;
        if (udf_at_done) udf_set = 1'b1;
        if (q.size() > 0 && q[0].gap == 0) begin
          drive_setup(q[0]);
          pre = 1'b1;
        end
        if (rst_at_done) begin
          presetn  = 1'b0;
          cur_done = 1'b0;
          #1;
          chk("rst_async_pready", {31'd0, pready}, 32'd0);
        end
        tick();
        cur_done = 1'b0;
        if (!pre) begin
          psel = 1'b0; penable = 1'b0;
          if (q.size() > 0 && q[0].gap > 1) repeat (q[0].gap - 1) tick();
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; ovf_set = 1'b0; udf_set = 1'b0; tcnt = 8'h00;
    repeat (3) tick();
    chk("rst_tdr", {24'd0, tdr}, 32'h00);
    chk("rst_tcr", {24'd0, tcr}, 32'h00);
    chk("rst_tsr_irq", {29'd0, tsr, irq}, 32'h0);
    chk("rst_pready", {31'd0, pready}, 32'd0);
    presetn = 1'b1;
    tick();
    push(8'h00, 1'b1, 8'h5A, 1, 1'b0);
    drain();
    chk("first_tdr", {24'd0, tdr}, 32'h5A);

    // load strobe, then enable
    push(8'h01, 1'b1, 8'h80, 1, 1'b0);
    drain();
    chk("tcr_load_on", {24'd0, tcr}, 32'h80);
    tick();
    chk("tcr_load_off", {24'd0, tcr}, 32'h00);
    push(8'h01, 1'b1, 8'h10, 1, 1'b0);
    drain();
    chk("tcr_en", {24'd0, tcr}, 32'h10);
    push(8'h01, 1'b0, 8'h00, 1, 1'b0);
    drain();
    chk("tcr_rd", {24'd0, last_rd}, 32'h10);
    push(8'h01, 1'b1, 8'hFF, 1, 1'b0);
    drain();
    chk("tcr_reserved", {24'd0, tcr}, 32'hB3);
    tick();
    chk("tcr_reserved_after", {24'd0, tcr}, 32'h33);

    // overflow flag and write-zero clear
    ovf_set = 1'b1;
    tick();
    push(8'h02, 1'b0, 8'h00, 1, 1'b0);
    drain();
    chk("tsr_ovf_rd", {24'd0, last_rd}, 32'h01);
    chk("irq_set", {31'd0, irq}, 32'd1);
    push(8'h02, 1'b1, 8'h00, 1, 1'b0);
    push(8'h02, 1'b0, 8'h00, 1, 1'b0);
    drain();
    chk("tsr_clr_rd", {24'd0, last_rd}, 32'h00);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // set wins over same-cycle clear
    ovf_set = 1'b1;
    tick();
    udf_at_done = 1'b1;
    push(8'h02, 1'b1, 8'h00, 1, 1'b0);
    drain();
    udf_at_done = 1'b0;
    chk("tsr_set_wins", {30'd0, tsr}, 32'h2);

    // errors and TCNT read
    push(8'h05, 1'b1, 8'h77, 1, 1'b0);
    drain();
    chk("err_unmapped", {31'd0, last_err}, 32'd1);
    chk("err_unmapped_tdr", {24'd0, tdr}, 32'h5A);
    push(8'h03, 1'b1, 8'h11, 1, 1'b0);
    drain();
    chk("err_ro", {31'd0, last_err}, 32'd1);
    tcnt = 8'hA5;
    push(8'h03, 1'b0, 8'h00, 1, 1'b0);
    drain();
    chk("tcnt_rd", {24'd0, last_rd}, 32'hA5);
    chk("tcnt_noerr", {31'd0, last_err}, 32'd0);

    // back-to-back writes
    hist.delete();
    push(8'h00, 1'b1, 8'hFF, 1, 1'b0);
    push(8'h00, 1'b1, 8'h3C, 0, 1'b0);
    drain();
    chk("b2b_cnt", hist.size(), 32'd2);
    if (hist.size() >= 2) chk("b2b_spacing", hist[1] - hist[0], 2 + WS);
    chk("b2b_tdr", {24'd0, tdr}, 32'h3C);

    // reset during the completing cycle of a write
    rst_at_done = 1'b1;
    push(8'h00, 1'b1, 8'h55, 1, 1'b0);
    drain();
    rst_at_done = 1'b0;
    tick();
    presetn = 1'b1;
    tick();
    chk("rst_abort_tdr", {24'd0, tdr}, 32'h00);
    push(8'h00, 1'b1, 8'h42, 1, 1'b0);
    drain();
    chk("post_rst_tdr", {24'd0, tdr}, 32'h42);

    // psel dropped in setup
    hist.delete();
    push(8'h00, 1'b1, 8'h99, 1, 1'b1);
    drain();
    tick();
    chk("abort_nopready", hist.size(), 32'd0);
    chk("abort_tdr", {24'd0, tdr}, 32'h42);

    // randomized traffic
    rand_side = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(4, 255));
      else a = 8'($urandom_range(0, 3));
      push(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2),
           ($urandom_range(0, 9) == 0));
    end
    drain();
    rand_side = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
